corefft_pingpong_buf: RTL and testbench
=======================================

Name: corefft_pingpong_buf

Overview:
Parametrised, single-clock ping-pong frame buffer for the COREFFT datapath. It generalises the fixed 512x64 two-port LSRAM buffer to two banks of configurable width and depth, a configurable read latency and bank-ownership tracking. A writer fills one bank while a reader drains the other, and banks are swapped by done-pulse handshakes. It sits between the FFT input sample loader and the butterfly/output stage.

Parameters:
WIDTH, 64, data word width in bits.
AWIDTH, 9, address width per bank; DEPTH = 2**AWIDTH words per bank.
RD_LATENCY, 1, cycles from accepted rd_en to DO/DO_valid; legal values are 1 or 2 (2 adds an output pipeline register).

Ports:
CLK  input  1  single clock, rising edge.
nGrst  input  1  asynchronous active-low reset.
wr_en  input  1  write strobe for the current write bank.
WADDR  input  AWIDTH  write address within the write bank.
DI  input  WIDTH  write data.
wr_done  input  1  pulse: the writer has finished the frame and commits the write bank.
wr_rdy  output  1  the current write bank is EMPTY and accepts writes.
rd_en  input  1  read strobe for the current read bank.
RADDR  input  AWIDTH  read address within the read bank.
rd_done  input  1  pulse: the reader has finished and releases the read bank.
rd_rdy  output  1  the current read bank is FULL.
DO_en  input  1  output register enable.
DO_rst  input  1  synchronous clear of the output register.
DO  output  WIDTH  read data.
DO_valid  output  1  DO carries data from an accepted read.
frames_full  output  2  number of FULL banks, 0..2.
wr_err  output  1  sticky: write or wr_done issued while wr_rdy=0.
rd_err  output  1  sticky: read or rd_done issued while rd_rdy=0.

Behaviour:
- Reset (nGrst=0, asynchronous):
  - Both banks EMPTY; wbank=0, rbank=0.
  - DO=0, DO_valid=0, wr_rdy=1, rd_rdy=0, frames_full=0, wr_err=0, rd_err=0.
  - RAM contents are not cleared.
  - A reset in the middle of a frame abandons all frames. No partial state survives.
- Bank state: each bank is EMPTY or FULL.
  - wr_rdy = (state[wbank]==EMPTY).
  - rd_rdy = (state[rbank]==FULL).
- Write:
  - wr_en & wr_rdy writes DI to RAM[{wbank,WADDR}] at the clock edge.
  - wr_en & !wr_rdy is dropped, RAM is unchanged, wr_err is set.
- wr_done & wr_rdy: state[wbank] becomes FULL and wbank toggles, visible in the next cycle. wr_en and wr_done in the same cycle: the write lands in the old bank first.
- wr_done & !wr_rdy: ignored; wr_err is set.
- Read:
  - rd_en & rd_rdy reads RAM[{rbank,RADDR}].
  - DO_valid asserts exactly RD_LATENCY cycles later, for one cycle per accepted read.
  - rd_en & !rd_rdy: no read is issued and rd_err is set.
- rd_done & rd_rdy: state[rbank] becomes EMPTY and rbank toggles. A read and rd_done in the same cycle: the read completes from the old bank and its data still emerges.
- rd_done & !rd_rdy: ignored; rd_err is set.
- Simultaneous wr_done and rd_done always target different banks, because a bank cannot be both EMPTY and FULL. Both take effect in the same cycle and frames_full updates by the net change.
- Reads and writes never hit the same bank, so no read-during-write bypass is needed.
- Output register:
  - DO_rst=1 gives DO=0 and DO_valid=0 on the next edge. DO_rst has priority over DO_en.
  - Otherwise DO/DO_valid update only when DO_en=1. With DO_en=0 they hold, and in-flight pipeline data is dropped.
- frames_full = count of FULL banks. It is 2 exactly when wr_rdy=0 and rd_rdy=1.
- wr_err/rd_err clear only on reset.

Optional Feature:
COREFFT_PINGPONG_BITREV_RD_EN.
- Defined: adds input rd_bitrev (1 bit). When rd_bitrev=1 at an accepted read, the effective address is RADDR bit-reversed across AWIDTH bits. This gives natural-order output from a decimation-in-time FFT.
- Undefined: port absent; reads always use RADDR unchanged.

Decomposition:
- Package corefft_buf_pkg:
  - bank_state_t enum {EMPTY, FULL}.
  - bitrev function, parametrised by width.
  - RD_LATENCY legality constant check.
- Sub-module corefft_sdp_ram: single-clock simple dual-port array of 2*DEPTH x WIDTH with a registered read. Address is AWIDTH+1 bits with the bank as MSB. It is instantiated once. Control, pipeline and output register live in the top level.

Test Plan:
- Common setup, unless noted: WIDTH=64, AWIDTH=3, RD_LATENCY=2.
- Reset: hold nGrst=0 -> DO=0, DO_valid=0, wr_rdy=1, rd_rdy=0, frames_full=0, both error flags 0.
- Fill bank0 with DI=64'hA0+i at WADDR=i (i=0..7), then wr_done -> next cycle rd_rdy=1, wr_rdy=1, frames_full=1. rd_en at RADDR=5 with DO_en=1 -> two cycles later DO=64'hA5, DO_valid=1 for one cycle.
- Fill and commit both banks -> frames_full=2, wr_rdy=0. Further wr_en at WADDR=0 with DI=64'hFF -> wr_err=1. Reading addr 0 of bank0 still returns 64'hA0.
- With no full bank, rd_done -> rd_err=1 and no state change. Simultaneous wr_done and rd_done at frames_full=1 -> frames_full stays 1 and both bank pointers toggle.
- DO=64'hA5 is held with DO_en=0 over 3 cycles -> DO unchanged. DO_rst=1 with DO_en=1 -> DO=0 and DO_valid=0 next cycle.
- Macro defined, rd_bitrev=1, RADDR=3'b001 -> DO=64'hA4. Separately, assert nGrst=0 mid-frame after 4 writes -> all flags return to reset values and wr_rdy=1.

Source files
------------

// File: rtl/corefft_pingpong_buf_pkg.sv
// Shared types and helpers for the COREFFT ping-pong frame buffer.
// Holds the bank state encoding, the address bit-reverse helper and the read-latency legality check.
package corefft_buf_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;
  localparam int BITREV_MAX_W   = 32;

  function automatic bit rd_latency_legal(input int lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

  // Reverses the low w bits of a. Bits at or above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] a,
                                                     input int w);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) r[i] = a[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/corefft_sdp_ram.sv
// Single-clock simple dual-port RAM (two banks, bank selected by the address MSB) with a registered read.
// The read register has an enable and a synchronous clear so that it can act as the output register.
module corefft_sdp_ram #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              nGrst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic              rclr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // The array itself is not reset: frame contents survive nGrst.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge CLK or negedge nGrst) begin
    if (!nGrst) begin
      rdata <= '0;
    end else if (rclr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/corefft_pingpong_buf.sv
// Two-bank ping-pong frame buffer: the writer fills one bank while the reader drains the other.
// Optional bit-reversed read addressing is compiled in with COREFFT_PINGPONG_BITREV_RD_EN.
module corefft_pingpong_buf
  import corefft_buf_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int AWIDTH     = 9,
  parameter int RD_LATENCY = 1
) (
  input  logic              CLK,
  input  logic              nGrst,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] WADDR,
  input  logic [WIDTH-1:0]  DI,
  input  logic              wr_done,
  output logic              wr_rdy,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] RADDR,
`ifdef COREFFT_PINGPONG_BITREV_RD_EN
  input  logic              rd_bitrev,
`endif
  input  logic              rd_done,
  output logic              rd_rdy,
  input  logic              DO_en,
  input  logic              DO_rst,
  output logic [WIDTH-1:0]  DO,
  output logic              DO_valid,
  output logic [1:0]        frames_full,
  output logic              wr_err,
  output logic              rd_err
);

  if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
    $error("corefft_pingpong_buf: RD_LATENCY must be 1 or 2");
  end

  bank_state_t bank_state     [2];
  bank_state_t bank_state_nxt [2];
  logic        wbank, wbank_nxt;
  logic        rbank, rbank_nxt;
  logic        wr_err_nxt, rd_err_nxt;

  logic        wr_accept, wr_commit;
  logic        rd_accept, rd_release;
  logic [AWIDTH-1:0] raddr_eff;

  logic             ram_re;
  logic             ram_clr;
  logic [WIDTH-1:0] ram_rdata;

  assign wr_rdy     = (bank_state[wbank] == EMPTY);
  assign rd_rdy     = (bank_state[rbank] == FULL);
  assign wr_accept  = wr_en   & wr_rdy;
  assign wr_commit  = wr_done & wr_rdy;
  assign rd_accept  = rd_en   & rd_rdy;
  assign rd_release = rd_done & rd_rdy;

  assign frames_full = {1'b0, (bank_state[0] == FULL)} + {1'b0, (bank_state[1] == FULL)};

`ifdef COREFFT_PINGPONG_BITREV_RD_EN
  assign raddr_eff = rd_bitrev ? AWIDTH'(bitrev(BITREV_MAX_W'(RADDR), AWIDTH)) : RADDR;
`else
  assign raddr_eff = RADDR;
`endif

  // A commit and a release can never name the same bank, so both updates apply independently.
  always_comb begin
    bank_state_nxt = bank_state;
    wbank_nxt      = wbank;
    rbank_nxt      = rbank;
    wr_err_nxt     = wr_err | (~wr_rdy & (wr_en | wr_done));
    rd_err_nxt     = rd_err | (~rd_rdy & (rd_en | rd_done));
    if (wr_commit) begin
      bank_state_nxt[wbank] = FULL;
      wbank_nxt             = ~wbank;
    end
    if (rd_release) begin
      bank_state_nxt[rbank] = EMPTY;
      rbank_nxt             = ~rbank;
    end
  end

  always_ff @(posedge CLK or negedge nGrst) begin
    if (!nGrst) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      wbank         <= 1'b0;
      rbank         <= 1'b0;
      wr_err        <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      bank_state[0] <= bank_state_nxt[0];
      bank_state[1] <= bank_state_nxt[1];
      wbank         <= wbank_nxt;
      rbank         <= rbank_nxt;
      wr_err        <= wr_err_nxt;
      rd_err        <= rd_err_nxt;
    end
  end

  corefft_sdp_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (AWIDTH + 1)
  ) u_ram (
    .CLK   (CLK),
    .nGrst (nGrst),
    .we    (wr_accept),
    .waddr ({wbank, WADDR}),
    .wdata (DI),
    .re    (ram_re),
    .rclr  (ram_clr),
    .raddr ({rbank, raddr_eff}),
    .rdata (ram_rdata)
  );

  if (RD_LATENCY == 1) begin : g_lat1
    // The RAM read register doubles as the output register.
    logic do_valid_q;

    assign ram_re  = rd_accept & DO_en;
    assign ram_clr = DO_rst;

    always_ff @(posedge CLK or negedge nGrst) begin
      if (!nGrst) begin
        do_valid_q <= 1'b0;
      end else if (DO_rst) begin
        do_valid_q <= 1'b0;
      end else if (DO_en) begin
        do_valid_q <= rd_accept;
      end
    end

    assign DO       = ram_rdata;
    assign DO_valid = do_valid_q;
  end else begin : g_lat2
    logic             s1_valid;
    logic [WIDTH-1:0] do_q;
    logic             do_valid_q;

    assign ram_re  = rd_accept;
    assign ram_clr = 1'b0;

    always_ff @(posedge CLK or negedge nGrst) begin
      if (!nGrst) begin
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= rd_accept;
      end
    end

    // DO keeps the last read word; a stage-1 word arriving while DO_en=0 is lost.
    always_ff @(posedge CLK or negedge nGrst) begin
      if (!nGrst) begin
        do_q       <= '0;
        do_valid_q <= 1'b0;
      end else if (DO_rst) begin
        do_q       <= '0;
        do_valid_q <= 1'b0;
      end else if (DO_en) begin
        do_valid_q <= s1_valid;
        if (s1_valid) do_q <= ram_rdata;
      end
    end

    assign DO       = do_q;
    assign DO_valid = do_valid_q;
  end

endmodule

// File: tb/tb_corefft_pingpong_buf.sv
// Scoreboard bench for corefft_pingpong_buf (WIDTH=64, AWIDTH=3, RD_LATENCY=2).
// Directed frame handshakes plus a randomized phase against a bank/array reference model.
module tb_corefft_pingpong_buf;
  localparam int W   = 64;
  localparam int AW  = 3;
  localparam int LAT = 2;
  localparam int DEP = 8;

  logic          CLK = 1'b0;
  logic          nGrst = 1'b0;
  logic          wr_en = 1'b0, wr_done = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
  logic          DO_en = 1'b1, DO_rst = 1'b0;
  logic [AW-1:0] WADDR = '0, RADDR = '0;
  logic [W-1:0]  DI = '0;
`ifdef COREFFT_PINGPONG_BITREV_RD_EN
  logic          rd_bitrev = 1'b0;
`endif
  logic          wr_rdy, rd_rdy, DO_valid, wr_err, rd_err;
  logic [W-1:0]  DO;
  logic [1:0]    frames_full;

  corefft_pingpong_buf #(.WIDTH(W), .AWIDTH(AW), .RD_LATENCY(LAT)) dut (
    .CLK(CLK), .nGrst(nGrst),
    .wr_en(wr_en), .WADDR(WADDR), .DI(DI), .wr_done(wr_done), .wr_rdy(wr_rdy),
    .rd_en(rd_en), .RADDR(RADDR),
`ifdef COREFFT_PINGPONG_BITREV_RD_EN
    .rd_bitrev(rd_bitrev),
`endif
    .rd_done(rd_done), .rd_rdy(rd_rdy),
    .DO_en(DO_en), .DO_rst(DO_rst), .DO(DO), .DO_valid(DO_valid),
    .frames_full(frames_full), .wr_err(wr_err), .rd_err(rd_err)
  );

  initial forever #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: per-bank contents, FULL flags, pointers, sticky errors.
  logic [W-1:0] mem_m [2][DEP];
  bit full_m [2];
  bit wb_m, rb_m, werr_m, rerr_m;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rev_addr(input int a);
    int r = 0;
    for (int i = 0; i < AW; i++) r += ((a >> i) & 1) << (AW - 1 - i);
    return r;
  endfunction

  function automatic logic [5:0] status_exp();
    int nf;
    nf = int'(full_m[0]) + int'(full_m[1]);
    return {!full_m[wb_m], full_m[rb_m], 2'(nf), werr_m, rerr_m};
  endfunction

  task automatic check_status(input string name);
    check(name, {58'd0, wr_rdy, rd_rdy, frames_full, wr_err, rd_err}, {58'd0, status_exp()});
  endtask

  task automatic model_reset();
    full_m[0] = 0; full_m[1] = 0;
    wb_m = 0; rb_m = 0; werr_m = 0; rerr_m = 0;
    sb.delete();
  endtask

  // One clock cycle of stimulus; model is updated from the pre-edge state, then status compared.
  task automatic step(input bit we, input int wa, input logic [W-1:0] di, input bit wd,
                      input bit re, input int ra, input bit brev, input bit rdn);
    bit wrdy, rrdy, owb, orb;
    int ea;
    wrdy = !full_m[wb_m];
    rrdy = full_m[rb_m];
    owb  = wb_m;
    orb  = rb_m;
    ea   = brev ? rev_addr(ra) : ra;
    if (we) begin
      if (wrdy) mem_m[owb][wa] = di; else werr_m = 1;
    end
    if (wd) begin
      if (wrdy) begin full_m[owb] = 1; wb_m = !owb; end else werr_m = 1;
    end
    if (re) begin
      if (rrdy) sb.push_back('{data: mem_m[orb][ea], due: cyc + LAT}); else rerr_m = 1;
    end
    if (rdn) begin
      if (rrdy) begin full_m[orb] = 0; rb_m = !orb; end else rerr_m = 1;
    end
    wr_en = we; WADDR = AW'(wa); DI = di; wr_done = wd;
    rd_en = re; RADDR = AW'(ra); rd_done = rdn;
`ifdef COREFFT_PINGPONG_BITREV_RD_EN
    rd_bitrev = brev;
`endif
    @(posedge CLK);
    @(negedge CLK);
    wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
`ifdef COREFFT_PINGPONG_BITREV_RD_EN
    rd_bitrev = 0;
`endif
    check_status("status");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill(input logic [W-1:0] base);
    for (int i = 0; i < DEP; i++) step(1, i, base + W'(i), 0, 0, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0, 0, 0);
  endtask

  // Monitor: compares every freshly registered DO_valid against the scoreboard.
  bit en_edge, rst_edge;
  always @(posedge CLK) begin
    en_edge  = DO_en;
    rst_edge = DO_rst;
  end

  always @(negedge CLK) begin
    if (nGrst) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("rd_latency_missed", W'(cyc), W'(sb[0].due));
        void'(sb.pop_front());
      end
      if (DO_valid && en_edge && !rst_edge) begin
        if (sb.size() == 0) begin
          check("unexpected_do_valid", W'(DO_valid), '0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rd_data", DO, e.data);
          check("rd_latency", W'(cyc), W'(e.due));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    check("reset_do", DO, '0);
    check("reset_do_valid", W'(DO_valid), '0);
    check_status("reset_status");
    nGrst = 1'b1;
    @(negedge CLK);

    // First frame into bank0, then a single read.
    fill(64'hA0);
    check("ff_after_commit", W'(frames_full), 64'd1);
    step(0, 0, '0, 0, 1, 5, 0, 0);
    idle(1);
    check("do_a5", DO, 64'hA5);

    DO_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("do_hold", DO, 64'hA5);
    end
    DO_en  = 1'b1;
    DO_rst = 1'b1;
    idle(1);
    check("do_rst_data", DO, '0);
    check("do_rst_valid", W'(DO_valid), '0);
    DO_rst = 1'b0;

    // Both banks full, then a rejected write and a read from bank0.
    fill(64'hB0);
    check("ff_two", W'(frames_full), 64'd2);
    step(1, 0, 64'hFF, 0, 0, 0, 0, 0);
    check("wr_err_set", W'(wr_err), 64'd1);
    step(0, 0, '0, 0, 1, 0, 0, 0);
    idle(2);

    // Release, simultaneous commit/release, drain, then release with nothing full.
    step(0, 0, '0, 0, 0, 0, 0, 1);
    step(0, 0, '0, 1, 0, 0, 0, 1);
    check("ff_simul", W'(frames_full), 64'd1);
    step(0, 0, '0, 0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 0, 0, 1);
    check("rd_err_set", W'(rd_err), 64'd1);

    // Randomized traffic; every location has been written, so all reads are defined.
    for (int n = 0; n < 400; n++) begin
      bit we, wd, re, rdn;
      we  = ($urandom_range(0, 99) < 55);
      wd  = ($urandom_range(0, 99) < 12);
      re  = ($urandom_range(0, 99) < 45);
      rdn = ($urandom_range(0, 99) < 12);
      step(we, $urandom_range(0, DEP - 1), {$urandom, $urandom}, wd,
           re, $urandom_range(0, DEP - 1), 0, rdn);
    end
    idle(3);

    // Reset in the middle of a frame.
    step(0, 0, '0, 0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, i, 64'hC0 + W'(i), 0, 0, 0, 0, 0);
    nGrst = 1'b0;
    model_reset();
    #1;
    check("midrst_do", DO, '0);
    check("midrst_do_valid", W'(DO_valid), '0);
    check("midrst_wr_rdy", W'(wr_rdy), 64'd1);
    check_status("midrst_status");
    @(negedge CLK);
    nGrst = 1'b1;
    @(negedge CLK);

`ifdef COREFFT_PINGPONG_BITREV_RD_EN
    fill(64'hA0);
    step(0, 0, '0, 0, 1, 1, 1, 0);
    idle(1);
    check("bitrev_do", DO, 64'hA4);
`endif

    idle(4);
    check("scoreboard_drained", W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
